// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: packs a little-endian byte stream into
// 32-bit words, holds the core in reset until the image is complete, then serves fetches.
module imem_loader #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter logic [31:0] NOP_WORD    = 32'h00000013
) (
  input  logic                          sysclk,
  input  logic                          sysreset,
  input  logic                          load_valid,
  input  logic [7:0]                    load_data,
  input  logic                          load_last,
  output logic                          load_ready,
  input  logic [31:0]                   inst_addr,
  output logic [31:0]                   instruction,
  output logic                          core_reset,
  output logic                          load_done,
  output logic                          load_err,
  output logic [$clog2(DEPTH_WORDS):0]  load_words
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned CW = AW + 1;

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    byte_cnt_q, byte_cnt_d;
  logic [31:0]   asm_q, asm_d;
  logic [CW-1:0] word_idx_q, word_idx_d;
  logic          err_q, err_d;

  logic          accept;
  logic          wr_en;
  logic [31:0]   merged;

  logic [31:0]   mem_q [DEPTH_WORDS];

  // State register; the array itself is deliberately outside reset.
  always_ff @(posedge sysclk) begin
    if (sysreset) begin
      state_q    <= ST_LOAD;
      byte_cnt_q <= 2'd0;
      asm_q      <= 32'd0;
      word_idx_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      asm_q      <= asm_d;
      word_idx_q <= word_idx_d;
      err_q      <= err_d;
    end
  end

  // Next-state: lanes above byte_cnt are always zero in the assembler, so a
  // short final word is naturally zero-padded.
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    asm_d      = asm_q;
    word_idx_d = word_idx_q;
    err_d      = err_q;
    wr_en      = 1'b0;
    accept     = load_valid && (state_q == ST_LOAD);
    merged     = asm_q | (32'(load_data) << {byte_cnt_q, 3'b000});

    if (accept) begin
      if ((byte_cnt_q == 2'd3) || load_last) begin
        asm_d      = 32'd0;
        byte_cnt_d = 2'd0;
        if (word_idx_q == CW'(DEPTH_WORDS)) begin
          err_d = 1'b1;
        end else begin
          wr_en      = 1'b1;
          word_idx_d = word_idx_q + CW'(1);
        end
      end else begin
        asm_d      = merged;
        byte_cnt_d = byte_cnt_q + 2'd1;
      end
      if (load_last) begin
        state_d = ST_RUN;
      end
    end
  end

  always_ff @(posedge sysclk) begin
    if (wr_en && !sysreset) begin
      mem_q[word_idx_q[AW-1:0]] <= merged;
    end
  end

  assign load_ready = (state_q == ST_LOAD);
  assign core_reset = (state_q == ST_LOAD);
  assign load_done  = (state_q == ST_RUN);
  assign load_err   = err_q;
  assign load_words = word_idx_q;

  // Fetch path: misaligned, out-of-range, or in-reset reads return the filler word.
  always_comb begin
    instruction = NOP_WORD;
    if (!core_reset && (inst_addr[1:0] == 2'b00) && (inst_addr[31:AW+2] == '0)) begin
      instruction = mem_q[inst_addr[AW+1:2]];
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a byte-level model queues expected words,
// which are read back through the fetch port once the loader reaches RUN.
module tb_imem_loader;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        sysclk = 1'b0;
  logic        sysreset;
  logic        load_valid;
  logic [7:0]  load_data;
  logic        load_last;
  logic [31:0] inst_addr;

  logic        ready_b, core_rst_b, done_b, err_b;
  logic [31:0] instr_b;
  logic [8:0]  words_b;
  logic        ready_s, core_rst_s, done_s, err_s;
  logic [31:0] instr_s;
  logic [2:0]  words_s;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int unsigned idx;
    logic [31:0] word;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned m_cnt;
  int unsigned m_idx;
  logic [31:0] m_asm;

  always #5 sysclk = ~sysclk;

  imem_loader u_big (
    .sysclk(sysclk), .sysreset(sysreset), .load_valid(load_valid),
    .load_data(load_data), .load_last(load_last), .load_ready(ready_b),
    .inst_addr(inst_addr), .instruction(instr_b), .core_reset(core_rst_b),
    .load_done(done_b), .load_err(err_b), .load_words(words_b)
  );

  imem_loader #(.DEPTH_WORDS(4)) u_small (
    .sysclk(sysclk), .sysreset(sysreset), .load_valid(load_valid),
    .load_data(load_data), .load_last(load_last), .load_ready(ready_s),
    .inst_addr(inst_addr), .instruction(instr_s), .core_reset(core_rst_s),
    .load_done(done_s), .load_err(err_s), .load_words(words_s)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0;
    m_idx = 0;
    m_asm = 32'd0;
    exp_q.delete();
  endtask

  task automatic do_reset();
    @(negedge sysclk);
    sysreset = 1'b1;
    @(posedge sysclk);
    @(posedge sysclk);
    model_reset();
    @(negedge sysclk);
    check("rst_ready", 32'(ready_b), 32'd1);
    check("rst_core_reset", 32'(core_rst_b), 32'd1);
    check("rst_done", 32'(done_b), 32'd0);
    check("rst_err_small", 32'(err_s), 32'd0);
    check("rst_words", 32'(words_b), 32'd0);
    check("rst_words_small", 32'(words_s), 32'd0);
    check("rst_instr", instr_b, NOP);
    sysreset = 1'b0;
  endtask

  // One accepted byte per call; the model mirrors the byte-lane packing.
  task automatic send_byte(input logic [7:0] d, input logic last);
    @(negedge sysclk);
    load_valid = 1'b1;
    load_data  = d;
    load_last  = last;
    @(posedge sysclk);
    #1;
    load_valid = 1'b0;
    load_last  = 1'b0;
    load_data  = 8'h00;
    m_asm = m_asm | (32'(d) << (8 * m_cnt));
    if (m_cnt == 3 || last) begin
      exp_q.push_back('{m_idx, m_asm});
      m_idx++;
      m_asm = 32'd0;
      m_cnt = 0;
    end else begin
      m_cnt++;
    end
  endtask

  task automatic idle_junk();
    @(negedge sysclk);
    load_valid = 1'b0;
    load_data  = 8'($urandom);
    load_last  = 1'b1;
    @(posedge sysclk);
    #1;
    load_last  = 1'b0;
  endtask

  task automatic drain();
    exp_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      @(negedge sysclk);
      inst_addr = 32'(e.idx) << 2;
      #1;
      check($sformatf("rd_big[%0d]", e.idx), instr_b, e.word);
      if (e.idx < 4) check($sformatf("rd_small[%0d]", e.idx), instr_s, e.word);
    end
  endtask

  task automatic send_image_a(input logic gaps);
    logic [7:0] img [8];
    img = '{8'h93, 8'h00, 8'hA0, 8'h00, 8'hB3, 8'h81, 8'h20, 8'h00};
    for (int i = 0; i < 8; i++) begin
      if (gaps) idle_junk();
      send_byte(img[i], i == 7);
      if (i == 6) begin
        check("a_core_reset_before_last", 32'(core_rst_b), 32'd1);
        inst_addr = 32'd0;
        #1;
        check("a_instr_in_reset", instr_b, NOP);
      end
    end
    check("a_core_reset_after_last", 32'(core_rst_b), 32'd0);
    check("a_done", 32'(done_b), 32'd1);
    check("a_ready", 32'(ready_b), 32'd0);
    check("a_words", 32'(words_b), 32'd2);
    check("a_model_words", 32'(m_idx), 32'(words_b));
    drain();
    inst_addr = 32'd4;
    #1;
    check("a_addr4", instr_b, 32'h002081B3);
  endtask

  initial begin
    sysreset   = 1'b1;
    load_valid = 1'b0;
    load_data  = 8'h00;
    load_last  = 1'b0;
    inst_addr  = 32'd0;
    model_reset();

    // Two-word image
    do_reset();
    send_image_a(1'b0);

    // RUN: misaligned / out-of-range reads and ignored loads
    @(negedge sysclk);
    inst_addr = 32'd2;
    #1;
    check("run_misaligned", instr_b, NOP);
    inst_addr = 32'd1024;
    #1;
    check("run_out_of_range_big", instr_b, NOP);
    inst_addr = 32'd16;
    #1;
    check("run_out_of_range_small", instr_s, NOP);
    @(negedge sysclk);
    load_valid = 1'b1;
    load_data  = 8'hEE;
    load_last  = 1'b1;
    @(posedge sysclk);
    @(posedge sysclk);
    #1;
    load_valid = 1'b0;
    load_last  = 1'b0;
    inst_addr  = 32'd0;
    #1;
    check("run_ignore_words", 32'(words_b), 32'd2);
    check("run_ignore_ready", 32'(ready_b), 32'd0);
    check("run_ignore_mem0", instr_b, 32'h00A00093);

    // Short final word is zero-padded
    do_reset();
    send_byte(8'h13, 1'b0);
    send_byte(8'h05, 1'b1);
    check("b_words", 32'(words_b), 32'd1);
    check("b_done", 32'(done_b), 32'd1);
    check("b_core_reset", 32'(core_rst_b), 32'd0);
    drain();
    inst_addr = 32'd0;
    #1;
    check("b_mem0", instr_b, 32'h00000513);

    // Gapped valid with junk while idle
    do_reset();
    send_image_a(1'b1);

    // Reset mid-load abandons the partial image
    do_reset();
    for (int i = 0; i < 6; i++) send_byte(8'(8'hC0 + i), 1'b0);
    check("r_words_mid", 32'(words_b), 32'd1);
    check("r_core_reset_mid", 32'(core_rst_b), 32'd1);
    do_reset();
    send_byte(8'h37, 1'b0);
    send_byte(8'h41, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h6F, 1'b0);
    check("r_core_reset_before_last", 32'(core_rst_b), 32'd1);
    check("r_words_before_last", 32'(words_b), 32'd1);
    send_byte(8'h00, 1'b1);
    check("r_core_reset_after", 32'(core_rst_b), 32'd0);
    check("r_words", 32'(words_b), 32'd2);
    drain();
    inst_addr = 32'd4;
    #1;
    check("r_mem1", instr_b, 32'h0000006F);

    // Overflow on the 4-word instance, 5 words into the 256-word instance
    do_reset();
    for (int i = 0; i < 20; i++) send_byte(8'(8'h10 + i), i == 19);
    check("o_words_small", 32'(words_s), 32'd4);
    check("o_err_small", 32'(err_s), 32'd1);
    check("o_done_small", 32'(done_s), 32'd1);
    check("o_ready_small", 32'(ready_s), 32'd0);
    check("o_words_big", 32'(words_b), 32'd5);
    check("o_err_big", 32'(err_b), 32'd0);
    drain();
    inst_addr = 32'd12;
    #1;
    check("o_small_mem3", instr_s, 32'h1F1E1D1C);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
